// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 keyboard receiver.
// Build option: PS2_PARITY_CHK_EN enables the odd-parity frame check.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } ps2_state_e;

    localparam int unsigned FRAME_LEN  = 11;
    localparam int unsigned START_IDX  = 0;
    localparam int unsigned PARITY_IDX = 9;
    localparam int unsigned STOP_IDX   = 10;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned IDLE_W     = 16;

`ifdef PS2_PARITY_CHK_EN
    localparam bit PARITY_CHK_EN = 1'b1;
`else
    localparam bit PARITY_CHK_EN = 1'b0;
`endif

    // Frame bits are held LSB-first as received: start, data[7:0], parity, stop.
    function automatic logic frame_ok(input logic [FRAME_LEN-1:0] f);
        logic par_ok;
        par_ok = ^f[PARITY_IDX:START_IDX+1];
        return !f[START_IDX] && f[STOP_IDX] && (!PARITY_CHK_EN || par_ok);
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// First-word fall-through byte FIFO; pointers carry an extra MSB for full/empty.
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    wr_q, wr_d;
    logic [PTR_W:0]    rd_q, rd_d;
    logic              do_push_c;
    logic              do_pop_c;

    always_comb begin
        empty_o   = (wr_q == rd_q);
        full_o    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
        do_pop_c  = pop_i && !empty_o;
        // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
        do_push_c = push_i && (!full_o || do_pop_c);
        wr_d      = do_push_c ? wr_q + (PTR_W+1)'(1) : wr_q;
        rd_d      = do_pop_c  ? rd_q + (PTR_W+1)'(1) : rd_q;
        data_o    = empty_o ? '0 : mem_q[rd_q[PTR_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_q[PTR_W-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes the bus, deframes 11-bit frames, queues scan codes.
// Build option: PS2_PARITY_CHK_EN additionally rejects frames with bad odd parity.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              overflow,
    output logic              frame_err
);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_LEN - 1);

    logic [2:0]           ps2c_q;
    logic [1:0]           ps2d_q;
    ps2_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overflow_q, overflow_d;
    logic                 fall_c;
    logic                 bit_c;
    logic                 push_c;
    logic                 fifo_empty;
    logic                 fifo_full;

    // Bus synchronizers reset to the idle-high level so reset release is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2c_q <= '1;
            ps2d_q <= '1;
        end else begin
            ps2c_q <= {ps2c_q[1:0], ps2_clk};
            ps2d_q <= {ps2d_q[0], ps2_data};
        end
    end

    assign fall_c = ps2c_q[2] && !ps2c_q[1];
    assign bit_c  = ps2d_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_c      = 1'b0;
        case (state_q)
            IDLE: begin
                idle_d = '0;
                if (fall_c && !bit_c) begin
                    state_d = RECV;
                    cnt_d   = CNT_W'(1);
                    shift_d = {bit_c, shift_q[FRAME_LEN-1:1]};
                end
            end
            RECV: begin
                if (fall_c) begin
                    idle_d  = '0;
                    shift_d = {bit_c, shift_q[FRAME_LEN-1:1]};
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    idle_d      = '0;
                    frame_err_d = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (frame_ok(shift_q)) begin
                    push_c = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idle_d  = '0;
            end
        endcase
        overflow_d = overflow_q || (push_c && fifo_full && !(rd_en && valid));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idle_q      <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    ps2_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_c),
        .push_data_i(shift_q[PARITY_IDX-1:START_IDX+1]),
        .pop_i      (rd_en),
        .data_o     (data),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign valid     = !fifo_empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: expected bytes queued per frame, checked on pop.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO    = 2000;
    localparam int unsigned HALF  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic [7:0] data;
    logic       valid;
    logic       overflow;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_keyboard_rx #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd_en    (rd_en),
        .data     (data),
        .valid    (valid),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    int         n_chk = 0;
    int         n_err = 0;
    int         err_pulses = 0;
    int         exp_err = 0;
    logic       exp_ovf = 1'b0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (rst && frame_err) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b, input logic lat_chk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (lat_chk) begin
            repeat (3) @(posedge clk);
            #1 check("valid_before_push", 32'(valid), 32'd0);
            @(posedge clk);
            #1 check("valid_after_done", 32'(valid), 32'd1);
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop_v, input logic lat_chk);
        logic par;
        logic ok;
        par = ~(^b) ^ par_flip;
`ifdef PS2_PARITY_CHK_EN
        ok = stop_v && !par_flip;
`else
        ok = stop_v;
`endif
        if (!ok) exp_err++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
        send_bit(par, 1'b0);
        send_bit(stop_v, lat_chk);
        repeat (10) @(negedge clk);
    endtask

    task automatic drain();
        logic [7:0] e;
        int         w;
        while (exp_q.size() > 0) begin
            w = 0;
            while (!valid && w < 200) begin
                @(negedge clk);
                w++;
            end
            e = exp_q.pop_front();
            check("valid_pending", 32'(valid), 32'd1);
            if (valid) begin
                check("data", 32'(data), 32'(e));
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        end
        check("valid_empty", 32'(valid), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single good frame with latency check
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
        check("err_0x1c", 32'(err_pulses), 32'(exp_err));
        drain();

        // Overflow: nine frames, no reads
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        check("overflow_set", 32'(overflow), 32'(exp_ovf));
        drain();
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Bad stop bit
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        check("err_stop", 32'(err_pulses), 32'(exp_err));
        check("valid_stop", 32'(valid), 32'd0);

        // Flipped parity: rejected only with the parity check built in
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        check("err_parity", 32'(err_pulses), 32'(exp_err));
        drain();

        // Partial frame then timeout
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        repeat (TO + 20) @(negedge clk);
        exp_err++;
        check("err_timeout", 32'(err_pulses), 32'(exp_err));
        check("state_idle", 32'(dut.state_q), 32'(IDLE));
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        check("err_after_to", 32'(err_pulses), 32'(exp_err));
        drain();

        // Reset mid-frame with bytes queued
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        check("queued_valid", 32'(valid), 32'd1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'(exp_ovf));
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("err_final", 32'(err_pulses), 32'(exp_err));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
